// File: rtl/dual_7_seg_decoder.sv
// dual_7_seg_decoder: debounces a pair of 7-segment patterns and presents each new
// stable pair as BCD digits plus binary value on a valid/ready output.
module dual_7_seg_decoder #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [6:0] seg_tens_i,
    input  logic [6:0] seg_ones_i,
    input  logic       ready_i,
    output logic       valid_o,
    output logic [3:0] tens_o,
    output logic [3:0] ones_o,
    output logic [6:0] value_o,
    output logic       err_o,
    output logic [7:0] err_cnt_o
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);

    typedef enum logic {SETTLE, PRESENT} state_t;

    state_t        state_q, state_d;
    logic [13:0]   sample_q, last_q, last_d, pair_q, pair_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          first_q, first_d;
    logic [3:0]    tens_q, tens_d, ones_q, ones_d;
    logic [6:0]    value_q, value_d;
    logic          err_q, err_d;
    logic [7:0]    err_cnt_q, err_cnt_d;

    logic [13:0]   pair_in;
    logic [3:0]    tens_dec, ones_dec;
    logic          dec_err, stable, new_pair;
    logic [6:0]    dec_value;

    function automatic logic [3:0] seg_to_digit(input logic [6:0] s);
        case (s)
            7'h3F:   return 4'd0;
            7'h06:   return 4'd1;
            7'h5B:   return 4'd2;
            7'h4F:   return 4'd3;
            7'h66:   return 4'd4;
            7'h6D:   return 4'd5;
            7'h7D:   return 4'd6;
            7'h07:   return 4'd7;
            7'h7F:   return 4'd8;
            7'h6F:   return 4'd9;
            default: return 4'hF;
        endcase
    endfunction

    assign pair_in   = {seg_tens_i, seg_ones_i};
    assign tens_dec  = seg_to_digit(sample_q[13:7]);
    assign ones_dec  = seg_to_digit(sample_q[6:0]);
    assign dec_err   = (tens_dec == 4'hF) || (ones_dec == 4'hF);
    assign dec_value = dec_err ? 7'd0 : 7'(tens_dec) * 7'd10 + 7'(ones_dec);
    assign stable    = cnt_q == CW'(STABLE_CYCLES);
    // A pair already emitted is suppressed until something different has been emitted.
    assign new_pair  = first_q || (sample_q != last_q);

    always_comb begin
        cnt_d = (pair_in == sample_q) ? (stable ? cnt_q : cnt_q + CW'(1)) : CW'(1);
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        pair_d    = pair_q;
        first_d   = first_q;
        tens_d    = tens_q;
        ones_d    = ones_q;
        value_d   = value_q;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        case (state_q)
            SETTLE: begin
                if (stable && new_pair) begin
                    state_d   = PRESENT;
                    pair_d    = sample_q;
                    tens_d    = tens_dec;
                    ones_d    = ones_dec;
                    value_d   = dec_value;
                    err_d     = dec_err;
                    err_cnt_d = (dec_err && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
                end
            end
            PRESENT: begin
                if (ready_i) begin
                    state_d = SETTLE;
                    last_d  = pair_q;
                    first_d = 1'b0;
                end
            end
            default: state_d = SETTLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= SETTLE;
            sample_q  <= '0;
            cnt_q     <= '0;
            first_q   <= 1'b1;
            last_q    <= '0;
            pair_q    <= '0;
            tens_q    <= '0;
            ones_q    <= '0;
            value_q   <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            sample_q  <= pair_in;
            cnt_q     <= cnt_d;
            first_q   <= first_d;
            last_q    <= last_d;
            pair_q    <= pair_d;
            tens_q    <= tens_d;
            ones_q    <= ones_d;
            value_q   <= value_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign valid_o   = state_q == PRESENT;
    assign tens_o    = tens_q;
    assign ones_o    = ones_q;
    assign value_o   = value_q;
    assign err_o     = err_q;
    assign err_cnt_o = err_cnt_q;
endmodule

// File: tb/tb_dual_7_seg_decoder.sv
// tb_dual_7_seg_decoder: randomized and directed checks against a history-based reference model.
module tb_dual_7_seg_decoder;
    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic       ready_i = 1'b0;
    logic [6:0] seg_tens_i = 7'h00;
    logic [6:0] seg_ones_i = 7'h00;
    logic       valid_o, err_o;
    logic [3:0] tens_o, ones_o;
    logic [6:0] value_o;
    logic [7:0] err_cnt_o;

    int checks = 0;
    int failures = 0;

    dual_7_seg_decoder #(.STABLE_CYCLES(S)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .seg_tens_i(seg_tens_i), .seg_ones_i(seg_ones_i),
        .ready_i(ready_i), .valid_o(valid_o), .tens_o(tens_o), .ones_o(ones_o),
        .value_o(value_o), .err_o(err_o), .err_cnt_o(err_cnt_o)
    );

    always #5 clk = ~clk;

    wire [24:0] dut_vec = {valid_o, tens_o, ones_o, value_o, err_o, err_cnt_o};

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // Reference: a reading is ready when the last S samples taken since reset agree.
    logic        m_valid, m_err, m_first;
    logic [3:0]  m_tens, m_ones;
    logic [6:0]  m_value;
    int          m_errcnt;
    logic [13:0] m_last, m_pair;
    logic [13:0] hist [$];

    function automatic logic [3:0] digit(input logic [6:0] p);
        for (int i = 0; i < 10; i++) if (seg_tab[i] == p) return 4'(i);
        return 4'hF;
    endfunction

    function automatic logic [24:0] exp_vec();
        return {m_valid, m_tens, m_ones, m_value, m_err, 8'(m_errcnt)};
    endfunction

    task automatic model_reset();
        m_valid = 0; m_err = 0; m_first = 1; m_tens = 0; m_ones = 0; m_value = 0;
        m_errcnt = 0; m_last = 0; m_pair = 0;
        hist.delete();
    endtask

    task automatic model_edge();
        int run = 0;
        if (hist.size() > 0)
            for (int i = hist.size() - 1; i >= 0 && hist[i] == hist[hist.size()-1]; i--) run++;
        if (!m_valid) begin
            if (run >= S && (m_first || hist[hist.size()-1] != m_last)) begin
                m_pair  = hist[hist.size()-1];
                m_tens  = digit(m_pair[13:7]);
                m_ones  = digit(m_pair[6:0]);
                m_err   = (m_tens == 4'hF) || (m_ones == 4'hF);
                m_value = m_err ? 7'd0 : 7'(int'(m_tens) * 10 + int'(m_ones));
                if (m_err && m_errcnt < 255) m_errcnt++;
                m_valid = 1;
            end
        end else if (ready_i) begin
            m_valid = 0;
            m_last  = m_pair;
            m_first = 0;
        end
        hist.push_back({seg_tens_i, seg_ones_i});
        if (hist.size() > S + 1) hist.delete(0);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_ni) model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 0;
        model_reset();
        #12;
        checks++;
        if (dut_vec !== 25'd0) begin
            failures++;
            $display("FAIL reset_state dut=%h exp=%h", dut_vec, 25'd0);
        end
        @(posedge clk);
        #1;
        rst_ni = 1;
    endtask

    task automatic test_first_zero();
        int lat = 0;
        seg_tens_i = 7'h3F; seg_ones_i = 7'h3F; ready_i = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (valid_o === 1'b1 && lat == 0) lat = i;
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL first_zero cyc=%0d dut=%h exp=%h", i, dut_vec, exp_vec());
            end
        end
        checks++;
        if (lat != S + 1) begin
            failures++;
            $display("FAIL latency got=%0d exp=%0d", lat, S + 1);
        end
        ready_i = 1;
        tick();
        ready_i = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (valid_o !== 1'b0 || dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL no_reemit cyc=%0d dut=%h exp=%h", i, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_digits();
        logic [13:0] pairs [3] = '{{7'h66, 7'h5B}, {7'h6F, 7'h6F}, {7'h7F, 7'h06}};
        int vals [3] = '{42, 99, 81};
        ready_i = 1;
        for (int p = 0; p < 3; p++) begin
            int seen = 0;
            {seg_tens_i, seg_ones_i} = pairs[p];
            for (int i = 0; i < 10; i++) begin
                tick();
                if (valid_o === 1'b1) begin
                    seen++;
                    checks++;
                    if (value_o !== 7'(vals[p])) begin
                        failures++;
                        $display("FAIL digit_value dut=%0d exp=%0d", value_o, vals[p]);
                    end
                end
                checks++;
                if (dut_vec !== exp_vec()) begin
                    failures++;
                    $display("FAIL digits p=%0d cyc=%0d dut=%h exp=%h", p, i, dut_vec, exp_vec());
                end
            end
            checks++;
            if (seen != 1) begin
                failures++;
                $display("FAIL digit_once p=%0d got=%0d exp=1", p, seen);
            end
        end
    endtask

    task automatic test_glitch();
        ready_i = 1;
        seg_tens_i = 7'h07;
        for (int t = 0; t < 30; t++) begin
            seg_ones_i = (t % 3 == 2) ? 7'h06 : 7'h07;
            tick();
            checks++;
            if (valid_o !== 1'b0 || dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL glitch t=%0d dut=%h exp=%h", t, dut_vec, exp_vec());
            end
        end
        seg_ones_i = 7'h07;
        for (int t = 0; t < 8; t++) begin
            tick();
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL glitch_settle t=%0d dut=%h exp=%h", t, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_hold();
        int n = 0;
        ready_i = 0;
        seg_tens_i = 7'h06; seg_ones_i = 7'h6D;
        while (valid_o !== 1'b1 && n < 20) begin tick(); n++; end
        checks++;
        if (valid_o !== 1'b1 || value_o !== 7'd15) begin
            failures++;
            $display("FAIL hold_15 valid=%b value=%0d exp valid=1 value=15", valid_o, value_o);
        end
        seg_ones_i = 7'h7D;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (value_o !== 7'd15 || valid_o !== 1'b1 || dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL hold_keep cyc=%0d dut=%h exp=%h", i, dut_vec, exp_vec());
            end
        end
        ready_i = 1;
        tick();
        ready_i = 0;
        checks++;
        if (valid_o !== 1'b0 || dut_vec !== exp_vec()) begin
            failures++;
            $display("FAIL hold_gap dut=%h exp=%h", dut_vec, exp_vec());
        end
        tick();
        checks++;
        if (valid_o !== 1'b1 || value_o !== 7'd16 || dut_vec !== exp_vec()) begin
            failures++;
            $display("FAIL hold_16 valid=%b value=%0d exp valid=1 value=16", valid_o, value_o);
        end
        ready_i = 1;
        tick();
    endtask

    task automatic test_errors();
        int n = 0;
        ready_i = 0;
        seg_tens_i = 7'h00; seg_ones_i = 7'h12;
        while (valid_o !== 1'b1 && n < 20) begin tick(); n++; end
        checks++;
        if ({valid_o, err_o, tens_o, ones_o, value_o, err_cnt_o} !== {1'b1, 1'b1, 4'hF, 4'hF, 7'd0, 8'd1}) begin
            failures++;
            $display("FAIL illegal err=%b tens=%h ones=%h value=%0d cnt=%0d exp 1 F F 0 1",
                     err_o, tens_o, ones_o, value_o, err_cnt_o);
        end
        ready_i = 1;
        for (int k = 0; k < 260; k++) begin
            seg_ones_i = 7'(k);
            for (int i = 0; i < S + 2; i++) begin
                tick();
                checks++;
                if (dut_vec !== exp_vec()) begin
                    failures++;
                    $display("FAIL err_sat k=%0d cyc=%0d dut=%h exp=%h", k, i, dut_vec, exp_vec());
                end
            end
        end
        checks++;
        if (err_cnt_o !== 8'd255) begin
            failures++;
            $display("FAIL err_cnt_sat dut=%0d exp=255", err_cnt_o);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 300; it++) begin
            int hold = $urandom_range(1, 7);
            seg_tens_i = ($urandom_range(0, 3) != 0) ? seg_tab[$urandom_range(0, 9)] : 7'($urandom);
            seg_ones_i = ($urandom_range(0, 3) != 0) ? seg_tab[$urandom_range(0, 9)] : 7'($urandom);
            for (int i = 0; i < hold; i++) begin
                ready_i = 1'($urandom);
                tick();
                checks++;
                if (dut_vec !== exp_vec()) begin
                    failures++;
                    $display("FAIL random it=%0d dut=%h exp=%h", it, dut_vec, exp_vec());
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int seen = 0;
        ready_i = 1;
        tick();
        tick();
        ready_i = 0;
        seg_tens_i = 7'h6D; seg_ones_i = 7'h6D;
        while (valid_o !== 1'b1 && n < 20) begin tick(); n++; end
        rst_ni = 0;
        model_reset();
        #1;
        checks++;
        if (valid_o !== 1'b0 || err_cnt_o !== 8'd0) begin
            failures++;
            $display("FAIL reset_mid valid=%b cnt=%0d exp valid=0 cnt=0", valid_o, err_cnt_o);
        end
        tick();
        rst_ni = 1;
        ready_i = 1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (valid_o === 1'b1) seen++;
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL reset_reemit cyc=%0d dut=%h exp=%h", i, dut_vec, exp_vec());
            end
        end
        checks++;
        if (seen != 1) begin
            failures++;
            $display("FAIL reemit_once got=%0d exp=1", seen);
        end
    endtask

    initial begin
        test_reset();
        test_first_zero();
        test_digits();
        test_glitch();
        test_hold();
        test_errors();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
